// File: rtl/button_event_ctrl_if.sv
// ---------------------------------------------------------------------------
// button_event_ctrl_if
// Event-slot bus between button_event_ctrl (master) and its consumer (slave).
//   evt_valid : slot holds an event
//   evt_ready : consumer takes the event while evt_valid=1
//   evt_btn   : index of the button that raised the event
//   evt_long  : 0 = press event, 1 = long/repeat event
//   evt_drop  : one-cycle pulse, an event was lost (pending bit already set)
// ---------------------------------------------------------------------------
interface button_event_ctrl_if #(
  parameter int N_BTN = 4
) ();
  localparam int BW = $clog2(N_BTN);

  logic          evt_valid;
  logic          evt_ready;
  logic [BW-1:0] evt_btn;
  logic          evt_long;
  logic          evt_drop;

  modport master (
    output evt_valid, evt_btn, evt_long, evt_drop,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_btn, evt_long, evt_drop,
    output evt_ready
  );
endinterface

// File: rtl/button_event_ctrl.sv
// ---------------------------------------------------------------------------
// button_event_ctrl
// Turns N_BTN debounced button levels into a stream of press and
// long/repeat events delivered through a single valid/ready event slot.
// Each button runs a small IDLE/ARMED/REPEAT FSM (btn_lane) that raises a
// press request on the rising edge and repeat requests while held. Requests
// latch into per-button pending bits; a round-robin arbiter moves one
// pending event into the slot whenever the slot is free.
//
// Ports
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active low
//   db_in  : [N_BTN-1:0] debounced levels, 1 = pressed
//   evt    : button_event_ctrl_if.master (evt_valid/ready/btn/long/drop)
// ---------------------------------------------------------------------------

// Per-button edge detect + hold timer. press_set/rep_set are single-cycle
// requests to set the matching pending bit in the parent.
module btn_lane #(
  parameter int LONG_CYC   = 16,
  parameter int REPEAT_CYC = 8,
  parameter int CW         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic db,
  output logic press_set,
  output logic rep_set
);
  typedef enum logic [1:0] {IDLE, ARMED, REPEAT} st_t;

  localparam logic [CW-1:0] LONG_M1 = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] REP_M1  = CW'(REPEAT_CYC - 1);

  st_t           state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      prev  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      prev  <= db;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_set = 1'b0;
    rep_set   = 1'b0;
    case (state)
      IDLE: begin
        if (db && !prev) begin
          press_set = 1'b1;
          state_n   = ARMED;
          cnt_n     = '0;
        end
      end
      ARMED: begin
        if (!db) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == LONG_M1) begin
          rep_set = 1'b1;
          state_n = REPEAT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!db) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == REP_M1) begin
          rep_set = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end
endmodule

module button_event_ctrl #(
  parameter int N_BTN      = 4,
  parameter int LONG_CYC   = 16,
  parameter int REPEAT_CYC = 8,
  parameter int CW         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_BTN-1:0]   db_in,
  button_event_ctrl_if.master evt
);
  localparam int BW = $clog2(N_BTN);

  typedef struct packed {
    logic          vld;
    logic [BW-1:0] btn;
    logic          lng;
  } evt_t;

  logic [N_BTN-1:0] press_set, rep_set;
  logic [N_BTN-1:0] press_pend, rep_pend, press_pend_n, rep_pend_n;
  logic [BW-1:0]    last_idx, gnt_idx;
  logic             gnt_vld, gnt_long, slot_free, load;
  logic             drop_n, drop_q;
  evt_t             slot;

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_lane
      btn_lane #(
        .LONG_CYC   (LONG_CYC),
        .REPEAT_CYC (REPEAT_CYC),
        .CW         (CW)
      ) u_lane (
        .clk       (clk),
        .rst       (rst),
        .db        (db_in[i]),
        .press_set (press_set[i]),
        .rep_set   (rep_set[i])
      );
    end
  endgenerate

  // Slot can take a new event when empty or being consumed this cycle.
  assign slot_free = ~slot.vld | evt.evt_ready;

  // Round-robin: scan from the button after the last one granted.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = (int'(last_idx) + 1 + k) % N_BTN;
      if (!gnt_vld && (press_pend[idx] || rep_pend[idx])) begin
        gnt_vld = 1'b1;
        gnt_idx = BW'(idx);
      end
    end
  end

  // Press is served ahead of repeat for the same button.
  assign gnt_long = ~press_pend[gnt_idx];
  assign load     = slot_free & gnt_vld;

  // Pending update: a new request beats the grant-clear of the same bit,
  // and a request onto a bit that stays set is reported as a drop.
  always_comb begin
    logic clr_p, clr_r;
    clr_p        = 1'b0;
    clr_r        = 1'b0;
    drop_n       = 1'b0;
    press_pend_n = press_pend;
    rep_pend_n   = rep_pend;
    for (int i = 0; i < N_BTN; i++) begin
      clr_p = load && (gnt_idx == BW'(i)) && !gnt_long;
      clr_r = load && (gnt_idx == BW'(i)) &&  gnt_long;
      press_pend_n[i] = press_set[i] | (press_pend[i] & ~clr_p);
      rep_pend_n[i]   = rep_set[i]   | (rep_pend[i]   & ~clr_r);
      if ((press_set[i] && press_pend[i] && !clr_p) ||
          (rep_set[i]   && rep_pend[i]   && !clr_r))
        drop_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      press_pend <= '0;
      rep_pend   <= '0;
      last_idx   <= BW'(N_BTN - 1);
      slot       <= '0;
      drop_q     <= 1'b0;
    end else begin
      press_pend <= press_pend_n;
      rep_pend   <= rep_pend_n;
      drop_q     <= drop_n;
      if (load) begin
        slot.vld <= 1'b1;
        slot.btn <= gnt_idx;
        slot.lng <= gnt_long;
        last_idx <= gnt_idx;
      end else if (slot_free) begin
        slot.vld <= 1'b0;
      end
    end
  end

  assign evt.evt_valid = slot.vld;
  assign evt.evt_btn   = slot.btn;
  assign evt.evt_long  = slot.lng;
  assign evt.evt_drop  = drop_q;
endmodule

// File: tb/tb_button_event_ctrl.sv
// ---------------------------------------------------------------------------
// tb_button_event_ctrl
// Directed bench for button_event_ctrl with default parameters
// (N_BTN=4, LONG_CYC=16, REPEAT_CYC=8). Inputs change 1 time unit after a
// rising edge; outputs are sampled at that same point, so each check sees
// the state produced by the edge just passed.
// ---------------------------------------------------------------------------
module tb_button_event_ctrl;
  logic       clk;
  logic       rst;
  logic [3:0] db_in;
  int         n_chk;
  int         n_fail;

  button_event_ctrl_if #(.N_BTN(4)) evt_if ();

  button_event_ctrl #(
    .N_BTN(4), .LONG_CYC(16), .REPEAT_CYC(8), .CW(8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .db_in (db_in),
    .evt   (evt_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int ev_n;
    int ev_c [8];
    int ev_l [8];
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    db_in  = 4'b0000;
    evt_if.evt_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_valid", evt_if.evt_valid, 1'b0);
    chk("rst_btn",   evt_if.evt_btn,   2'd0);
    chk("rst_long",  evt_if.evt_long,  1'b0);
    chk("rst_drop",  evt_if.evt_drop,  1'b0);
    tick();
    tick();
    rst = 1'b1;

    // Single press on button 2, held 3 cycles
    db_in[2] = 1'b1;
    tick();
    chk("p2_edge_k_valid", evt_if.evt_valid, 1'b0);
    tick();
    chk("p2_valid", evt_if.evt_valid, 1'b1);
    chk("p2_btn",   evt_if.evt_btn,   2'd2);
    chk("p2_long",  evt_if.evt_long,  1'b0);
    tick();
    chk("p2_gone", evt_if.evt_valid, 1'b0);
    db_in[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("p2_quiet", evt_if.evt_valid, 1'b0);
    end

    // Button 0 held 40 cycles: press, then repeats at +16, +24, +32
    ev_n = 0;
    db_in[0] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (c == 40) db_in[0] = 1'b0;
      tick();
      if (evt_if.evt_valid === 1'b1) begin
        if (ev_n < 8) begin
          ev_c[ev_n] = c;
          ev_l[ev_n] = int'(evt_if.evt_long);
        end
        ev_n++;
        chk("hold_btn", evt_if.evt_btn, 2'd0);
      end
    end
    chk("hold_count", ev_n, 4);
    if (ev_n == 4) begin
      chk("hold_c0", ev_c[0], 1);
      chk("hold_l0", ev_l[0], 0);
      chk("hold_c1", ev_c[1], 17);
      chk("hold_l1", ev_l[1], 1);
      chk("hold_c2", ev_c[2], 25);
      chk("hold_l2", ev_l[2], 1);
      chk("hold_c3", ev_c[3], 33);
      chk("hold_l3", ev_l[3], 1);
    end

    // All four pressed together after reset: 0,1,2,3 back to back
    do_reset();
    db_in = 4'b1111;
    tick();
    chk("all_k_valid", evt_if.evt_valid, 1'b0);
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("all_valid", evt_if.evt_valid, 1'b1);
      chk("all_btn",   evt_if.evt_btn,   b);
      chk("all_long",  evt_if.evt_long,  1'b0);
    end
    db_in = 4'b0000;
    tick();
    chk("all_done", evt_if.evt_valid, 1'b0);

    // Backpressure: btn1 then btn3 with ready low
    evt_if.evt_ready = 1'b0;
    db_in[1] = 1'b1;
    tick();
    tick();
    chk("bp_valid", evt_if.evt_valid, 1'b1);
    chk("bp_btn",   evt_if.evt_btn,   2'd1);
    db_in[3] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_hold_valid", evt_if.evt_valid, 1'b1);
      chk("bp_hold_btn",   evt_if.evt_btn,   2'd1);
      chk("bp_hold_long",  evt_if.evt_long,  1'b0);
    end
    evt_if.evt_ready = 1'b1;
    tick();
    chk("bp_next_valid", evt_if.evt_valid, 1'b1);
    chk("bp_next_btn",   evt_if.evt_btn,   2'd3);
    db_in = 4'b0000;
    tick();
    chk("bp_empty", evt_if.evt_valid, 1'b0);

    // Drop: slot held by btn2, btn1 pressed twice while its press pends
    evt_if.evt_ready = 1'b0;
    db_in[2] = 1'b1;
    tick();
    tick();
    chk("dr_slot_btn", evt_if.evt_btn, 2'd2);
    db_in[2] = 1'b0;
    db_in[1] = 1'b1;
    tick();
    chk("dr_first_nodrop", evt_if.evt_drop, 1'b0);
    db_in[1] = 1'b0;
    tick();
    db_in[1] = 1'b1;
    tick();
    chk("dr_second_drop", evt_if.evt_drop, 1'b1);
    db_in[1] = 1'b0;
    tick();
    chk("dr_pulse_end", evt_if.evt_drop, 1'b0);
    evt_if.evt_ready = 1'b1;
    tick();
    chk("dr_deliver_valid", evt_if.evt_valid, 1'b1);
    chk("dr_deliver_btn",   evt_if.evt_btn,   2'd1);
    chk("dr_deliver_long",  evt_if.evt_long,  1'b0);
    tick();
    chk("dr_only_one", evt_if.evt_valid, 1'b0);

    // Reset mid-operation with btn2 held across release
    evt_if.evt_ready = 1'b0;
    db_in[2] = 1'b1;
    tick();
    tick();
    chk("mr_pre_valid", evt_if.evt_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk("mr_async_valid", evt_if.evt_valid, 1'b0);
    chk("mr_async_btn",   evt_if.evt_btn,   2'd0);
    chk("mr_async_long",  evt_if.evt_long,  1'b0);
    chk("mr_async_drop",  evt_if.evt_drop,  1'b0);
    tick();
    tick();
    chk("mr_in_rst_valid", evt_if.evt_valid, 1'b0);
    rst = 1'b1;
    evt_if.evt_ready = 1'b1;
    tick();
    chk("mr_edge_valid", evt_if.evt_valid, 1'b0);
    tick();
    chk("mr_press_valid", evt_if.evt_valid, 1'b1);
    chk("mr_press_btn",   evt_if.evt_btn,   2'd2);
    chk("mr_press_long",  evt_if.evt_long,  1'b0);
    tick();
    chk("mr_after", evt_if.evt_valid, 1'b0);
    db_in = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
